// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer from memory-stage decode to the shared data-RAM port.
// Latency: error T+1, aligned store T+2, aligned load T+3, split store T+3, split load T+5; +1 per ungranted cycle.
// Backpressure: req_ready only in IDLE; mem_* held stable until mem_gnt; resp_valid is a one-cycle pulse, never stalled.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake; req_memop, req_rs1, req_imm, req_wdata carry the op
//   resp_valid/resp_rdata/resp_err   completion pulse with extended load data or error flag
//   mem_en/mem_gnt             RAM port request/grant; mem_addr (word aligned), mem_we, mem_wdata, mem_rdata
//
// Build option: LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses into two word accesses;
// without it those requests complete immediately with resp_err=1.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_memop,
  input  logic [31:0]       req_rs1,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_WAIT0, S_ACC1, S_WAIT1, S_RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;  // illegal encoding

  function automatic logic [1:0] f_size(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b0111: f_size = SZ_B;
      4'b0001, 4'b0101, 4'b1000: f_size = SZ_H;
      4'b0010, 4'b0110:          f_size = SZ_W;
      default:                   f_size = SZ_X;
    endcase
  endfunction

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ea;
  logic [3:0]        r_op;
  logic [31:0]       r_wdata;
  logic              r_split;
  logic              r_err;
  logic [31:0]       r_lo;
  logic [31:0]       r_hi;

  // Request-side decode, evaluated on the incoming op while in IDLE.
  logic [31:0]       w_sum;
  logic [ADDR_W-1:0] w_ea;
  logic [1:0]        w_req_size;
  logic              w_req_illegal;
  logic              w_req_mis;
  logic              w_req_split;
  logic              w_req_err;

  assign w_sum         = req_rs1 + req_imm;
  assign w_ea          = w_sum[ADDR_W-1:0];
  assign w_req_size    = f_size(req_memop);
  assign w_req_illegal = (w_req_size == SZ_X);
  // A halfword at offset 1 stays inside one word, so only offset 3 crosses.
  assign w_req_mis     = ((w_req_size == SZ_H) && (w_ea[1:0] == 2'b11)) ||
                         ((w_req_size == SZ_W) && (w_ea[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_req_split = !w_req_illegal && w_req_mis;
  assign w_req_err   = w_req_illegal;
`else
  assign w_req_split = 1'b0;
  assign w_req_err   = w_req_illegal || w_req_mis;
`endif

  // Decode of the latched op drives lanes and load extension.
  logic [1:0]        w_size;
  logic              w_store;
  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [7:0]        w_lanes;
  logic [63:0]       w_data64;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_ld_word;
  logic [31:0]       w_ld_ext;

  assign w_size    = f_size(r_op);
  assign w_store   = (r_op[3:2] == 2'b00);
  assign w_off     = r_ea[1:0];
  assign w_mask    = (w_size == SZ_B) ? 4'b0001 :
                     (w_size == SZ_H) ? 4'b0011 :
                     (w_size == SZ_W) ? 4'b1111 : 4'b0000;
  // Lanes and data span two words; the upper half feeds the second access.
  assign w_lanes   = {4'b0000, w_mask} << w_off;
  assign w_data64  = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_waddr   = {r_ea[ADDR_W-1:2], 2'b00};
  assign w_ld_word = 32'({r_hi, r_lo} >> {w_off, 3'b000});

  always_comb begin
    w_ld_ext = 32'b0;
    case (r_op)
      4'b0100: w_ld_ext = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
      4'b0101: w_ld_ext = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
      4'b0110: w_ld_ext = w_ld_word;
      4'b0111: w_ld_ext = {24'b0, w_ld_word[7:0]};
      4'b1000: w_ld_ext = {16'b0, w_ld_word[15:0]};
      default: w_ld_ext = 32'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 32'b0;
    resp_err    = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    mem_we      = 4'b0;
    mem_wdata   = 32'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_err ? S_RESP : S_ACC0;
      end
      S_ACC0: begin
        mem_en   = 1'b1;
        mem_addr = w_waddr;
        if (w_store) begin
          mem_we    = w_lanes[3:0];
          mem_wdata = w_data64[31:0];
        end
        if (mem_gnt) begin
          if (!w_store)     w_state_nxt = S_WAIT0;
          else if (r_split) w_state_nxt = S_ACC1;
          else              w_state_nxt = S_RESP;
        end
      end
      S_WAIT0: w_state_nxt = r_split ? S_ACC1 : S_RESP;
      S_ACC1: begin
        mem_en   = 1'b1;
        mem_addr = w_waddr + ADDR_W'(4);  // wraps at the top of the address space
        if (w_store) begin
          mem_we    = w_lanes[7:4];
          mem_wdata = w_data64[63:32];
        end
        if (mem_gnt) w_state_nxt = w_store ? S_RESP : S_WAIT1;
      end
      S_WAIT1: w_state_nxt = S_RESP;
      S_RESP: begin
        resp_valid  = 1'b1;
        resp_err    = r_err;
        resp_rdata  = (r_err || w_store) ? 32'b0 : w_ld_ext;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ea    <= '0;
      r_op    <= 4'b0;
      r_wdata <= 32'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
      r_lo    <= 32'b0;
      r_hi    <= 32'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_ea    <= w_ea;
            r_op    <= req_memop;
            r_wdata <= req_wdata;
            r_split <= w_req_split;
            r_err   <= w_req_err;
            r_lo    <= 32'b0;
            r_hi    <= 32'b0;  // stays zero for single-access loads
          end
        end
        S_WAIT0: r_lo <= mem_rdata;
        S_WAIT1: r_hi <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's memory-stage decode and the shared data-RAM port. It accepts one load/store per request handshake, computes the effective address, arbitrates for the RAM port through a request/grant pair, drives byte-lane write enables, and returns sign- or zero-extended load data. The FSM replaces the purely combinational memory-op path. Misaligned accesses are split into two word accesses when enabled.

## Interface
- `ADDR_W`, 32, effective-address and RAM-address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `req_valid`  in  1  core presents a memory op
- `req_ready`  out  1  block accepts a request (high only in IDLE)
- `req_memop`  in  4  0000 sb, 0001 sh, 0010 sw, 0100 lb, 0101 lh, 0110 lw, 0111 lbu, 1000 lhu; all others illegal
- `req_rs1`  in  32  base address
- `req_imm`  in  32  sign-extended offset
- `req_wdata`  in  32  store data (rs2)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  illegal op or unsupported misalignment, valid with resp_valid
- `mem_en`  out  1  RAM access request
- `mem_gnt`  in  1  RAM port granted this cycle
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0
- `mem_we`  out  4  byte write enables, 0 for reads
- `mem_wdata`  out  32  lane-aligned store data
- `mem_rdata`  in  32  read data, valid the cycle after a granted read

## Operation
- States: IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch ea = rs1+imm (mod 2^ADDR_W), op, wdata, off = ea[1:0].
  - Illegal op: go to RESP with err=1. No RAM access.
  - Misaligned means a halfword with off=3, or a word with off≠0. With the macro, set the split flag. Without it, go to RESP with err=1.
  - Otherwise go to ACC0.
- Lane math:
  - size mask m = 0001 (byte), 0011 (half), 1111 (word).
  - 8-bit mask M = m<<off.
  - 64-bit data D = {32'b0,wdata}<<(8·off).
  - ACC0 uses M[3:0] and D[31:0]. ACC1 uses M[7:4] and D[63:32].
- ACC0: mem_en=1, mem_addr={ea[31:2],00}, mem_we = store ? M[3:0] : 0. Hold all outputs stable until mem_gnt.
  - On grant: a store goes to ACC1 if split, else RESP. A load goes to WAIT0.
- WAIT0: capture mem_rdata into lo. Go to ACC1 if split, else RESP.
- ACC1: same as ACC0, but mem_addr = word address + 4, wrapping 0xFFFFFFFC → 0x00000000.
  - On grant: a store goes to RESP, a load goes to WAIT1.
- WAIT1: capture mem_rdata into hi, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load data is ({hi,lo}>>(8·off)) truncated to the access size. lb/lh sign-extend; lbu/lhu/lw zero-extend. hi=0 when not split.
- resp_valid carries no back-pressure; the core must sample it in that cycle.

## Timing
- Request accepted in cycle T.
- Aligned load: ACC0 at T+1. With grant in that cycle, WAIT0 at T+2 and resp_valid at T+3.
- Aligned store: resp_valid at T+2.
- Split load: resp_valid at T+5. Split store: resp_valid at T+3.
- Each cycle without grant adds one cycle.
- Error response: resp_valid at T+1.
- Next request is accepted no earlier than the cycle after RESP.
- Reset values (rst_n low at a rising edge): state IDLE, split/lo/hi/ea cleared.
  - Outputs: resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 from the first cycle after reset. Requests presented while rst_n=0 are ignored.
- Reset mid-operation aborts the op: no response, and mem_en drops at that edge. A store whose first half was already granted stays partially written.
- req_valid in any non-IDLE state is ignored; req_ready=0 there.

## Configuration
- `LSU_MISALIGN_SPLIT_EN`
  - Defined: misaligned halfword/word accesses complete as two RAM accesses (ACC0/ACC1) with correct lane merge.
  - Undefined: ACC1/WAIT1 are unreachable and may be omitted. Misaligned requests return resp_err=1, resp_rdata=0, with no RAM access.

## Test plan
- sw rs1=0x100, imm=4, wdata=0xDEADBEEF, gnt tied 1 → one access: mem_addr=0x104, mem_we=1111, mem_wdata=0xDEADBEEF; resp_valid at T+2, rdata 0.
- lb ea=0x203, mem_rdata=0x80FF_FF12 → mem_addr=0x200, we=0000; resp_rdata=0xFFFFFF80 at T+3. Same address with lbu → 0x00000080.
- sh ea=0x102, wdata=0x0000ABCD, gnt low 3 cycles → mem_en held with addr 0x100, we=1100, wdata=0xABCD0000 unchanged; resp at T+5.
- Macro on: lw ea=0x1FE, reads 0x1FC=0x4433_2211, 0x200=0x8877_6655 → resp_rdata=0x66554433 at T+5. Macro off: same request → resp_err=1 at T+1, mem_en never asserted.
- memop=0011 → resp_err=1, rdata 0, no mem_en. Back-to-back requests: the second is accepted only when req_ready=1 after RESP.
- Assert rst_n=0 during ACC0 of a load → next cycle IDLE, mem_en=0, no resp_valid. A fresh lw completes normally afterwards.
